// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Multi-cycle load/store sequencer between the pipeline MEM stage and a
//   data memory with an en/ack handshake. One request is accepted at a time.
//   Misaligned requests are answered with an error and never reach memory.
//   Aligned requests hold mem_en until mem_ack or until MAX_WAIT access
//   cycles have passed. Loads return the selected lane, zero- or
//   sign-extended.
//
// Parameters
//   MAX_WAIT   access cycles without mem_ack before a timeout error (>=1)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   req_valid  request present
//   req_ready  controller idle and able to accept
//   req_we     1 = store, 0 = load
//   req_op     0 word, 1 byte u, 2 byte s, 3 half u, 4 half s, 5..7 word
//   req_addr   byte address
//   req_wdata  store data (low bits used for sb/sh)
//   mem_en     memory access strobe, held until mem_ack
//   mem_we     write strobe, valid with mem_en
//   mem_be     byte enables
//   mem_addr   word-aligned address
//   mem_wdata  lane-replicated store data
//   mem_ack    memory completes the access this cycle
//   mem_rdata  raw word read data
//   rsp_valid  one-cycle response pulse
//   rsp_err    misaligned or timeout, valid with rsp_valid
//   rsp_rdata  extended load data, 0 for stores and errors
module mem_access_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata
);

  localparam int unsigned TW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t        r_state,   w_state_nxt;
  logic [2:0]    r_op,      w_op_nxt;
  logic [1:0]    r_lane,    w_lane_nxt;
  logic [TW-1:0] r_timer,   w_timer_nxt;
  logic          r_mem_en,  w_mem_en_nxt;
  logic          r_mem_we,  w_mem_we_nxt;
  logic [3:0]    r_mem_be,  w_mem_be_nxt;
  logic [31:0]   r_mem_addr, w_mem_addr_nxt;
  logic [31:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic          r_rsp_err,   w_rsp_err_nxt;
  logic [31:0]   r_rsp_rdata, w_rsp_rdata_nxt;

  // Request decode (used only while idle)
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_misaligned;
  logic [3:0]  w_req_be;
  logic [31:0] w_req_wdata;

  always_comb begin
    w_is_byte    = (req_op == 3'd1) || (req_op == 3'd2);
    w_is_half    = (req_op == 3'd3) || (req_op == 3'd4);
    w_misaligned = 1'b0;
    w_req_be     = 4'b1111;
    w_req_wdata  = req_wdata;
    if (w_is_byte) begin
      w_req_be    = 4'b0001 << req_addr[1:0];
      w_req_wdata = {4{req_wdata[7:0]}};
    end else if (w_is_half) begin
      w_misaligned = req_addr[0];
      w_req_be     = req_addr[1] ? 4'b1100 : 4'b0011;
      w_req_wdata  = {2{req_wdata[15:0]}};
    end else begin
      w_misaligned = (req_addr[1:0] != 2'b00);
    end
  end

  // Lane selection and extension of the returned word
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_op)
      3'd1:    w_load = {24'd0, w_byte};
      3'd2:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd3:    w_load = {16'd0, w_half};
      3'd4:    w_load = {{16{w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_lane_nxt      = r_lane;
    w_timer_nxt     = r_timer;
    w_mem_en_nxt    = r_mem_en;
    w_mem_we_nxt    = r_mem_we;
    w_mem_be_nxt    = r_mem_be;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_rdata_nxt = r_rsp_rdata;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_misaligned) begin
            // Memory-side outputs are left untouched for rejected requests
            w_state_nxt     = ST_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
          end else begin
            w_state_nxt     = ST_ACCESS;
            w_op_nxt        = req_op;
            w_lane_nxt      = req_addr[1:0];
            w_timer_nxt     = '0;
            w_mem_en_nxt    = 1'b1;
            w_mem_we_nxt    = req_we;
            w_mem_be_nxt    = w_req_be;
            w_mem_addr_nxt  = {req_addr[31:2], 2'b00};
            w_mem_wdata_nxt = w_req_wdata;
          end
        end
      end

      ST_ACCESS: begin
        // An ack in the final allowed cycle takes priority over the timeout
        if (mem_ack) begin
          w_state_nxt     = ST_RESP;
          w_mem_en_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = r_mem_we ? '0 : w_load;
        end else if (r_timer == TIMER_LAST) begin
          w_state_nxt     = ST_RESP;
          w_mem_en_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_mem_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_lane      <= '0;
      r_timer     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_lane      <= w_lane_nxt;
      r_timer     <= w_timer_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Randomized and directed bench for mem_access_ctrl. A simple memory
//   responder acks after a chosen number of access cycles (or never);
//   expected bus values and responses come from arithmetic reference
//   functions describing the load/store rules.
module tb_mem_access_ctrl;

  localparam int unsigned MW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mem_access_ctrl #(.MAX_WAIT(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit op_is_byte(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2);
  endfunction

  function automatic bit op_is_half(input logic [2:0] op);
    return (op == 3'd3) || (op == 3'd4);
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] op, input logic [31:0] addr);
    if (op_is_byte(op)) return 1'b0;
    if (op_is_half(op)) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  function automatic logic [31:0] ref_be(input logic [2:0] op, input logic [31:0] addr);
    int unsigned lane = addr % 4;
    if (op_is_byte(op)) return 32'd1 << lane;
    if (op_is_half(op)) return (lane >= 2) ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] wd);
    if (op_is_byte(op)) return (wd & 32'hFF) * 32'h0101_0101;
    if (op_is_half(op)) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int unsigned lane = addr % 4;
    logic [31:0] v;
    if (op_is_byte(op)) begin
      v = (rd >> (8 * lane)) & 32'hFF;
      if (op == 3'd2 && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (op_is_half(op)) begin
      v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
      if (op == 3'd4 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Drive one request from an idle negedge and follow it to the next idle
  // negedge. ack_at = access cycle (1-based) in which mem_ack is given,
  // 0 or beyond MW means never.
  task automatic run_req(input bit we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int unsigned ack_at);
    bit          acked;
    logic        exp_err;
    logic [31:0] exp_rd;
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    mem_ack   = 1'($urandom_range(0, 1));   // ack while idle must be ignored
    mem_rdata = $urandom;
    @(negedge clk);
    mem_ack   = 1'b0;
    // Garbage request while busy must not be accepted
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    req_op    = 3'($urandom_range(0, 7));
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (ref_misaligned(op, addr)) begin
      exp_err = 1'b1;
      exp_rd  = '0;
      chk("mis_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("mis_rsp_err", 32'(rsp_err), 32'd1);
      chk("mis_rsp_rdata", rsp_rdata, 32'd0);
      chk("mis_mem_en", 32'(mem_en), 32'd0);
      chk("mis_ready", 32'(req_ready), 32'd0);
    end else begin
      acked = 1'b0;
      for (int unsigned k = 1; k <= MW; k++) begin
        chk("acc_mem_en", 32'(mem_en), 32'd1);
        chk("acc_mem_we", 32'(mem_we), 32'(we));
        chk("acc_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("acc_mem_be", 32'(mem_be), ref_be(op, addr));
        if (we) chk("acc_mem_wdata", mem_wdata, ref_wdata(op, wdata));
        chk("acc_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("acc_ready", 32'(req_ready), 32'd0);
        mem_ack   = (k == ack_at);
        mem_rdata = mem_ack ? rdata : $urandom;
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        @(negedge clk);
        if (k == ack_at) begin
          acked = 1'b1;
          break;
        end
      end
      mem_ack   = 1'($urandom_range(0, 1));   // ack outside access must be ignored
      mem_rdata = $urandom;
      exp_err = !acked;
      exp_rd  = (acked && !we) ? ref_load(op, addr, rdata) : 32'd0;
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_mem_en", 32'(mem_en), 32'd0);
      chk("rsp_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rsp_err_hold", 32'(rsp_err), 32'(exp_err));
    chk("post_rsp_rdata_hold", rsp_rdata, exp_rd);
    chk("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          we;
    logic [2:0]  op;
    logic [31:0] addr;
    int unsigned ack_at;

    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases
    run_req(1'b0, 3'd2, 32'h0000_1003, 32'h0,         32'h80FF_1234, 1);  // lb
    run_req(1'b0, 3'd3, 32'h0000_2002, 32'h0,         32'h9ABC_5678, 1);  // lhu
    run_req(1'b0, 3'd4, 32'h0000_2002, 32'h0,         32'h9ABC_5678, 2);  // lh
    run_req(1'b1, 3'd1, 32'h0000_0011, 32'h0000_00A5, 32'h0,         1);  // sb
    run_req(1'b1, 3'd3, 32'h0000_0006, 32'h0000_1234, 32'h0,         3);  // sh
    run_req(1'b1, 3'd0, 32'h0000_0006, 32'h1111_2222, 32'h0,         1);  // sw misaligned
    run_req(1'b0, 3'd0, 32'h0000_0002, 32'h0,         32'h0,         1);  // lw misaligned
    run_req(1'b0, 3'd4, 32'h0000_0005, 32'h0,         32'h0,         1);  // lh misaligned
    run_req(1'b0, 3'd0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0);  // timeout
    run_req(1'b0, 3'd0, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, MW); // ack in last cycle
    run_req(1'b0, 3'd6, 32'h0000_0040, 32'h0,         32'h1357_9BDF, 1);  // op 6 as word
    run_req(1'b0, 3'd1, 32'h0000_0002, 32'h0,         32'h00F0_0000, 1);  // lbu high bit set

    // Reset in the middle of an access
    chk("pre_reset_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'h0000_0200;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_mem_en_before", 32'(mem_en), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset   = 1'b1;
    mem_ack = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_idle_ready", 32'(req_ready), 32'd1);
      chk("abort_idle_mem_en", 32'(mem_en), 32'd0);
    end
    mem_ack = 1'b0;

    // Randomized traffic
    for (int unsigned n = 0; n < 150; n++) begin
      we   = 1'($urandom_range(0, 1));
      op   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (op_is_half(op)) addr[0] = 1'b0;
        else if (!op_is_byte(op)) addr[1:0] = 2'b00;
      end
      if ($urandom_range(0, 4) == 0) ack_at = $urandom_range(0, MW + 2);
      else ack_at = $urandom_range(1, 3);
      run_req(we, op, addr, $urandom, $urandom, ack_at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
